// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / halt sequencer for a 5-stage MIPS pipeline.
// Serves MEM-stage redirects, load-use stalls and a debug halt with
// pipeline drain and single-step. Outputs are combinational from the
// registered state and the current inputs.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_redirect,
  input  logic             halt_req,
  input  logic             step_pulse,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10,
    ST_STEP   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_q, redir_d;
  logic             load_use;

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // $zero is never a real dependency.
  always_comb begin
    load_use = idex_memread && (idex_rt != 5'd0) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  end

  // Next-state and output decode: redirect beats load-use beats halt/step.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_enable   = 1'b0;
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      halted = (state_q == ST_HALTED);
      if (exmem_redirect) begin
        // Squash the three wrong-path slots; PC loads the target.
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        case (state_q)
          ST_RUN: begin
            if (halt_req) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end
          end
          ST_DRAIN, ST_STEP: begin
            // Redirect refills the pipe with live work, so restart the drain.
            drain_cnt_d = DRAIN_LOAD;
            if (!halt_req) begin
              state_d = ST_RUN;
            end
          end
          default: begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        endcase
      end else if (load_use) begin
        // One bubble into ID/EX while PC and IF/ID hold; drain count frozen.
        idex_flush = 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            pc_enable   = 1'b1;
            ifid_enable = 1'b1;
            if (halt_req) begin
              // Halt takes effect immediately: this fetch is dropped.
              pc_enable   = 1'b0;
              ifid_flush  = 1'b1;
              state_d     = ST_DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end
          end
          ST_DRAIN, ST_STEP: begin
            // PC holds, so the dropped instruction is refetched on resume.
            ifid_enable = 1'b1;
            ifid_flush  = 1'b1;
            if (!halt_req) begin
              state_d     = ST_RUN;
              drain_cnt_d = '0;
            end else if (drain_cnt_q <= DRAIN_ONE) begin
              state_d     = ST_HALTED;
              drain_cnt_d = '0;
            end else begin
              drain_cnt_d = drain_cnt_q - DRAIN_ONE;
            end
          end
          default: begin
            ifid_enable = 1'b1;
            ifid_flush  = 1'b1;
            if (!halt_req) begin
              state_d = ST_RUN;
            end else if (step_pulse) begin
              // Let exactly one instruction in, then drain it out.
              pc_enable   = 1'b1;
              ifid_flush  = 1'b0;
              state_d     = ST_STEP;
              drain_cnt_d = DRAIN_LOAD;
            end
          end
        endcase
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    redir_d = redir_q;
    if (!pc_enable && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    if (exmem_redirect && (redir_q != {CNT_W{1'b1}})) begin
      redir_d = redir_q + 1'b1;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      stall_q     <= '0;
      redir_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_q     <= stall_d;
      redir_q     <= redir_d;
    end
  end

  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: table-driven vectors plus hand-written
// halt/step/reset sequences, checked through an expected-result queue.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ifid_rs, ifid_rt, idex_rt;
  logic          ifid_uses_rt, idex_memread, exmem_redirect, halt_req, step_pulse;
  logic          pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush, halted;
  logic [CW-1:0] stall_cycles, redirect_count;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_redirect(exmem_redirect), .halt_req(halt_req), .step_pulse(step_pulse),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // outs = {pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush, halted}
  typedef struct {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] irt;
    logic       redir;
    logic       halt;
    logic       step;
    logic [5:0] outs;
  } vec_t;

  typedef struct {
    string         name;
    logic [5:0]    outs;
    logic [CW-1:0] stall;
    logic [CW-1:0] redir;
  } exp_t;

  exp_t          sb[$];
  vec_t          tbl[8];
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_redir = '0;
  int            n_total = 0;
  int            n_pass  = 0;
  int            pc_ones;

  localparam logic [5:0] O_RUN    = 6'b110000;
  localparam logic [5:0] O_LU     = 6'b000100;
  localparam logic [5:0] O_REDIR  = 6'b111110;
  localparam logic [5:0] O_DRAIN  = 6'b011000;
  localparam logic [5:0] O_HALTED = 6'b011001;
  localparam logic [5:0] O_STEP1  = 6'b110001;
  localparam logic [5:0] O_RST    = 6'b000000;

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic mr, input logic [4:0] irt,
                              input logic rd, input logic h, input logic s,
                              input logic [5:0] o);
    vec_t v;
    v.rst_n = r; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memread = mr; v.irt = irt;
    v.redir = rd; v.halt = h; v.step = s; v.outs = o;
    return v;
  endfunction

  // Count a single comparison result.
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  // Compare the oldest expected record against what the DUT shows now.
  task automatic score();
    exp_t e;
    e = sb.pop_front();
    check({e.name, ".outs"},
          {26'd0, pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush, halted},
          {26'd0, e.outs});
    check({e.name, ".stall"}, {28'd0, stall_cycles}, {28'd0, e.stall});
    check({e.name, ".redir"}, {28'd0, redirect_count}, {28'd0, e.redir});
    $display("%s: outs=%b stall=%0d redir=%0d", e.name,
             {pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush, halted},
             stall_cycles, redirect_count);
  endtask

  // Drive one cycle of stimulus, queue its expectation, check mid-cycle,
  // then advance the counter model across the coming clock edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(posedge clk); #1;
    reset = v.rst_n; ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.uses_rt;
    idex_memread = v.memread; idex_rt = v.irt; exmem_redirect = v.redir;
    halt_req = v.halt; step_pulse = v.step;
    e.name = name; e.outs = v.outs; e.stall = m_stall; e.redir = m_redir;
    sb.push_back(e);
    @(negedge clk);
    if (pc_enable) pc_ones++;
    score();
    if (!v.rst_n) begin
      m_stall = '0;
      m_redir = '0;
    end else begin
      if (!v.outs[5] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (v.redir && m_redir != '1) m_redir = m_redir + 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle, hold, hreq, stp, rel, rdh;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
    hreq = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_DRAIN);
    hold = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_HALTED);
    stp  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, O_STEP1);
    rel  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, O_HALTED);
    rdh  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111111);

    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST);    // in reset: all forced low
    tbl[1] = idle;
    tbl[2] = mk(1, 8, 0, 0, 1, 8, 0, 0, 0, O_LU);     // lw $t0; add uses $t0 as rs
    tbl[3] = mk(1, 9, 8, 1, 1, 8, 0, 0, 0, O_LU);     // match on rt, rt is read
    tbl[4] = mk(1, 9, 8, 0, 1, 8, 0, 0, 0, O_RUN);    // match on rt, rt not read
    tbl[5] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, O_RUN);    // load to $zero
    tbl[6] = mk(1, 8, 0, 0, 0, 8, 0, 0, 0, O_RUN);    // not a load
    tbl[7] = mk(1, 8, 0, 0, 1, 8, 1, 0, 0, O_REDIR);  // redirect wins over load-use

    reset = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0; idex_memread = 0;
    idex_rt = 0; exmem_redirect = 0; halt_req = 0; step_pulse = 0; pc_ones = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, O_REDIR), "beq_taken");
    apply(idle, "after_beq");

    // Halt from RUN: halted must appear exactly 5 cycles after the request.
    apply(hreq, "halt_req");
    for (int i = 1; i <= 4; i++) apply(hreq, $sformatf("drain%0d", i));
    apply(hold, "halted");
    // Single step: one fetch, then a full drain back to HALTED.
    pc_ones = 0;
    apply(stp, "step");
    for (int i = 1; i <= 4; i++) apply(hreq, $sformatf("stepdrain%0d", i));
    apply(hold, "rehalted");
    check("step_fetches", pc_ones, 1);
    // Redirect while halted restarts a drain.
    apply(rdh, "halt_redirect");
    for (int i = 1; i <= 4; i++) apply(hreq, $sformatf("rdrain%0d", i));
    apply(hold, "halted2");
    // Release: step ignored, RUN next cycle.
    apply(rel, "release");
    apply(idle, "resume");

    // Redirect coincident with halt request still enters DRAIN; drop halt there.
    apply(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, O_REDIR), "redir_halt");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN), "drain_abort");
    apply(idle, "run_again");

    // Reset mid-drain.
    apply(hreq, "halt_b");
    apply(hreq, "drain_b");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST), "reset_mid");
    apply(idle, "post_reset");

    // Saturate the stall counter.
    for (int i = 0; i < 20; i++) apply(tbl[2], $sformatf("sat%0d", i));
    @(negedge clk);
    check("stall_sat", {28'd0, stall_cycles}, 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
